// File: rtl/sseg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, SHOW, DONE} state_t;
   localparam int BCD_W = 4;
   localparam int MAX_DISPLAY = 99;
   localparam logic [BCD_W-1:0] OVERFLOW_DIGIT = 4'hF;
endpackage

// File: rtl/sseg_display_arbiter_if.sv
// Requester/display bundle between the arbiter and its environment.
interface sseg_display_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int VALUE_W = 7
);
   import sseg_pkg::*;
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]              req;
   logic [NUM_REQ-1:0][VALUE_W-1:0] value;
   logic [NUM_REQ-1:0]              ack;
   logic [ID_W-1:0]                 grant_id;
   logic                            busy;
   logic [BCD_W-1:0]                ones;
   logic [BCD_W-1:0]                tens;

   modport master (output req, value, input ack, grant_id, busy, ones, tens);
   modport slave  (input req, value, output ack, grant_id, busy, ones, tens);
endinterface

// File: rtl/sseg_display_arbiter_bin2bcd_seq.sv
// Iterative double-dabble: one bit per cycle, digits load atomically on the last step.
module bin2bcd_seq
   import sseg_pkg::*;
#(
   parameter int VALUE_W = 7
) (
   input  logic               clock_in,
   input  logic               reset,
   input  logic               start,
   input  logic [VALUE_W-1:0] bin,
   output logic               done,
   output logic [BCD_W-1:0]   ones,
   output logic [BCD_W-1:0]   tens
);
   localparam int CNT_W = $clog2(VALUE_W + 1);

   logic [VALUE_W-1:0] bin_q;
   logic [2*BCD_W-1:0] bcd_q, bcd_adj, bcd_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               running, ovf_q;

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < 2; d++)
         if (bcd_q[d*BCD_W +: BCD_W] >= BCD_W'(5))
            bcd_adj[d*BCD_W +: BCD_W] = bcd_q[d*BCD_W +: BCD_W] + BCD_W'(3);
      bcd_nxt = {bcd_adj[2*BCD_W-2:0], bin_q[VALUE_W-1]};
      done    = running && (cnt == CNT_W'(VALUE_W - 1));
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt     <= '0;
         running <= 1'b0;
         ovf_q   <= 1'b0;
         ones    <= '0;
         tens    <= '0;
      end else if (start) begin
         bin_q   <= bin;
         bcd_q   <= '0;
         cnt     <= '0;
         running <= 1'b1;
         // Overflow is judged on the value as granted, before it is shifted away.
         ovf_q   <= (bin > VALUE_W'(MAX_DISPLAY));
      end else if (running) begin
         bin_q <= bin_q << 1;
         bcd_q <= bcd_nxt;
         cnt   <= cnt + 1'b1;
         if (done) begin
            running <= 1'b0;
            ones    <= ovf_q ? OVERFLOW_DIGIT : bcd_nxt[BCD_W-1:0];
            tens    <= ovf_q ? OVERFLOW_DIGIT : bcd_nxt[2*BCD_W-1:BCD_W];
         end
      end
   end
endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 2-digit display: grant, convert to BCD, hold, acknowledge.
module sseg_display_arbiter
   import sseg_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int VALUE_W     = 7
) (
   input logic                  clock_in,
   input logic                  reset,
   sseg_display_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr, pick, grant_q;
   logic [HC_W-1:0] hold_cnt;
   logic            found, start, conv_done, hold_end;
   int              idx;

   // First set request at or above the pointer, wrapping past NUM_REQ-1.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req[idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[ID_W-1:0];
         end
      end
   end

   assign hold_end     = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
   assign bus.grant_id = grant_q;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      bus.ack   = '0;
      bus.busy  = (state != IDLE);
      case (state)
         IDLE:    if (found) begin
                     start     = 1'b1;
                     state_nxt = CONVERT;
                  end
         CONVERT: if (conv_done) state_nxt = SHOW;
         SHOW:    if (hold_end) state_nxt = DONE;
         DONE: begin
            bus.ack[grant_q] = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         ptr      <= '0;
         grant_q  <= '0;
         hold_cnt <= '0;
      end else begin
         if (start) grant_q <= pick;
         hold_cnt <= (state == SHOW) ? hold_cnt + 1'b1 : '0;
         if (state == DONE)
            ptr <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   bin2bcd_seq #(.VALUE_W(VALUE_W)) u_bcd (
      .clock_in (clock_in),
      .reset    (reset),
      .start    (start),
      .bin      (bus.value[pick]),
      .done     (conv_done),
      .ones     (bus.ones),
      .tens     (bus.tens)
   );
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed scenarios for the display arbiter with NUM_REQ=4, HOLD_CYCLES=4.
module tb_sseg_display_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sseg_display_arbiter_if #(.NUM_REQ(4), .VALUE_W(7)) bus ();

   sseg_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4), .VALUE_W(7)) dut (
      .clock_in (clk),
      .reset    (rst),
      .bus      (bus)
   );

   // ack must never be multi-hot
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(bus.ack) > 1) begin
            errors++;
            $display("FAIL ack_onehot: ack=%b, required at most one bit set", bus.ack);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.req   = '0;
      bus.value = '0;
      rst = 1'b1;
      tick(3);
      checks++;
      if ({bus.ones, bus.tens, bus.ack, bus.grant_id, bus.busy} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: ones=%0h tens=%0h ack=%b gid=%0d busy=%b, required all 0",
                  bus.ones, bus.tens, bus.ack, bus.grant_id, bus.busy);
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_single();
      bus.value[0] = 7'd57;
      bus.req = 4'b0001;                         // cycle 0
      tick(1);
      bus.req = 4'b0000;
      tick(6);                                   // cycle 7
      checks++;
      if (bus.busy !== 1'b1 || bus.ones !== 4'd0 || bus.tens !== 4'd0) begin
         errors++;
         $display("FAIL single_c7: busy=%b tens=%0h ones=%0h, required 1/0/0", bus.busy, bus.tens, bus.ones);
      end
      tick(1);                                   // cycle 8
      checks++;
      if (bus.tens !== 4'd5 || bus.ones !== 4'd7) begin
         errors++;
         $display("FAIL single_digits: tens=%0h ones=%0h, required 5/7", bus.tens, bus.ones);
      end
      tick(3);                                   // cycle 11
      checks++;
      if (bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_ack_early: ack=%b, required 0000", bus.ack);
      end
      tick(1);                                   // cycle 12
      checks++;
      if (bus.ack !== 4'b0001) begin
         errors++;
         $display("FAIL single_ack: ack=%b, required 0001", bus.ack);
      end
      tick(1);                                   // cycle 13
      checks++;
      if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: busy=%b ack=%b, required 0/0000", bus.busy, bus.ack);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_t [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
      logic [3:0] exp_o [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      logic [3:0] exp_ack;
      do_reset();
      bus.value[0] = 7'd10;
      bus.value[1] = 7'd21;
      bus.value[2] = 7'd32;
      bus.value[3] = 7'd43;
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick(1);                                // cycle 1 of this grant
         checks++;
         if (bus.grant_id !== 2'(k % 4)) begin
            errors++;
            $display("FAIL rr_grant%0d: grant_id=%0d, required %0d", k, bus.grant_id, k % 4);
         end
         if (k == 4) bus.req = 4'b0000;
         tick(7);                                // cycle 8
         checks++;
         if (bus.tens !== exp_t[k % 4] || bus.ones !== exp_o[k % 4]) begin
            errors++;
            $display("FAIL rr_digits%0d: tens=%0h ones=%0h, required %0h/%0h",
                     k, bus.tens, bus.ones, exp_t[k % 4], exp_o[k % 4]);
         end
         tick(4);                                // cycle 12
         exp_ack = 4'b0001 << (k % 4);
         checks++;
         if (bus.ack !== exp_ack) begin
            errors++;
            $display("FAIL rr_ack%0d: ack=%b, required %b", k, bus.ack, exp_ack);
         end
         tick(1);                                // cycle 13 == next cycle 0
      end
   endtask

   task automatic test_overflow();
      logic [6:0] vals  [4] = '{7'd99, 7'd100, 7'd127, 7'd0};
      logic [3:0] exp_t [4] = '{4'd9, 4'hF, 4'hF, 4'd0};
      logic [3:0] exp_o [4] = '{4'd9, 4'hF, 4'hF, 4'd0};
      for (int k = 0; k < 4; k++) begin
         bus.value[0] = vals[k];
         bus.req = 4'b0001;
         tick(1);
         bus.req = 4'b0000;
         tick(7);                                // cycle 8
         checks++;
         if (bus.tens !== exp_t[k] || bus.ones !== exp_o[k]) begin
            errors++;
            $display("FAIL ovf_%0d: tens=%0h ones=%0h, required %0h/%0h",
                     vals[k], bus.tens, bus.ones, exp_t[k], exp_o[k]);
         end
         tick(5);                                // cycle 13
      end
   endtask

   task automatic test_sample_once();
      bus.value[2] = 7'd64;
      bus.req = 4'b0100;
      tick(3);                                   // cycle 3, mid-CONVERT
      bus.value[2] = 7'd11;
      tick(5);                                   // cycle 8, SHOW
      bus.req = 4'b0000;
      checks++;
      if (bus.tens !== 4'd6 || bus.ones !== 4'd4) begin
         errors++;
         $display("FAIL latch_digits: tens=%0h ones=%0h, required 6/4", bus.tens, bus.ones);
      end
      tick(3);                                   // cycle 11
      checks++;
      if (bus.tens !== 4'd6 || bus.ones !== 4'd4 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL latch_hold: tens=%0h ones=%0h busy=%b, required 6/4/1", bus.tens, bus.ones, bus.busy);
      end
      tick(1);                                   // cycle 12
      checks++;
      if (bus.ack !== 4'b0100) begin
         errors++;
         $display("FAIL latch_ack: ack=%b, required 0100", bus.ack);
      end
      tick(1);
   endtask

   task automatic test_reset_mid();
      // Serve requester 2 first so the pointer sits at 3 before the reset.
      bus.value[2] = 7'd5;
      bus.req = 4'b0100;
      tick(1);
      bus.req = 4'b0000;
      tick(12);                                  // cycle 13, idle
      bus.req = 4'b0100;
      tick(1);
      bus.req = 4'b0000;
      tick(8);                                   // cycle 9, SHOW showing 05
      rst = 1'b1;
      tick(1);                                   // cycle 10
      rst = 1'b0;
      checks++;
      if (bus.ones !== 4'd0 || bus.tens !== 4'd0 || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
         errors++;
         $display("FAIL rst_mid: ones=%0h tens=%0h busy=%b ack=%b, required 0/0/0/0000",
                  bus.ones, bus.tens, bus.busy, bus.ack);
      end
      for (int c = 0; c < 5; c++) begin
         tick(1);
         checks++;
         if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_ack: ack=%b busy=%b, required 0000/0", bus.ack, bus.busy);
         end
      end
      bus.value[0] = 7'd33;
      bus.value[3] = 7'd44;
      bus.req = 4'b1001;
      tick(1);
      bus.req = 4'b0000;
      checks++;
      if (bus.grant_id !== 2'd0) begin
         errors++;
         $display("FAIL rst_ptr: grant_id=%0d, required 0", bus.grant_id);
      end
      tick(7);                                   // cycle 8
      checks++;
      if (bus.tens !== 4'd3 || bus.ones !== 4'd3) begin
         errors++;
         $display("FAIL rst_regrant: tens=%0h ones=%0h, required 3/3", bus.tens, bus.ones);
      end
      tick(5);
   endtask

   task automatic test_back_to_back();
      bus.value[3] = 7'd88;
      bus.req = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         tick(1);                                // cycle 1 of grant k
         checks++;
         if (bus.grant_id !== 2'd3 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_grant%0d: grant_id=%0d busy=%b, required 3/1", k, bus.grant_id, bus.busy);
         end
         tick(10);                               // cycle 11
         checks++;
         if (bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_early%0d: ack=%b, required 0000", k, bus.ack);
         end
         tick(1);                                // cycle 12, 13 after previous ack
         checks++;
         if (bus.ack !== 4'b1000 || bus.tens !== 4'd8 || bus.ones !== 4'd8) begin
            errors++;
            $display("FAIL b2b_ack%0d: ack=%b tens=%0h ones=%0h, required 1000/8/8",
                     k, bus.ack, bus.tens, bus.ones);
         end
         if (k == 2) bus.req = 4'b0000;
         tick(1);                                // cycle 13, IDLE re-grant cycle
         checks++;
         if (bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_idle%0d: busy=%b ack=%b, required 0/0000", k, bus.busy, bus.ack);
         end
      end
      tick(2);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop: busy=%b, required 0", bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_overflow();
      test_sample_once();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
